// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and ID-stage handshake.
interface if_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  // Fetch queue side
  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  // Memory / branch unit / ID stage side
  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a
// one-cycle synchronous imem and buffers {instr, pc, pc+4} for the ID stage.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic          valid_q, valid_nxt;
  entry_t        head_q, head_nxt;
  entry_t        push_entry;
  logic          pop, push, issue;

  // Handshake decode, issue decision and next FIFO/head state
  always_comb begin
    pop        = valid_q & ~rst & bus.id_ready;
    push       = inflight & ~bus.redirect_valid;
    // Count the outstanding response as occupied; a same-cycle pop frees a slot.
    issue      = ~rst & ~bus.redirect_valid &
                 ((OW'(count) + OW'(inflight)) < (OW'(DEPTH) + OW'(pop)));
    push_entry = '{instr: bus.imem_rdata, pc: inflight_pc, pc4: inflight_pc + 32'd4};

    rd_ptr_nxt   = pop  ? rd_ptr + PW'(1) : rd_ptr;
    wr_ptr_nxt   = push ? wr_ptr + PW'(1) : wr_ptr;
    count_nxt    = count + CW'(push) - CW'(pop);
    fetch_pc_nxt = issue ? fetch_pc + 32'd4 : fetch_pc;
    valid_nxt    = (count_nxt != '0);

    // The new head bypasses the array when the pushed entry lands at the read slot.
    head_nxt = '0;
    if (valid_nxt) begin
      if (push && (wr_ptr == rd_ptr_nxt)) head_nxt = push_entry;
      else                                head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Control state: reset beats redirect, redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      valid_q     <= 1'b0;
      head_q      <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= bus.redirect_pc & 32'hFFFF_FFFC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      valid_q     <= 1'b0;
      head_q      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      inflight    <= issue;
      if (issue) inflight_pc <= fetch_pc;
      valid_q     <= valid_nxt;
      head_q      <= head_nxt;
    end
  end

  // FIFO storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= push_entry;
  end

  // Outputs are forced to their reset values while rst is asserted
  assign bus.imem_req  = issue;
  assign bus.imem_addr = rst ? RESET_PC : fetch_pc;
  assign bus.id_valid  = valid_q & ~rst;
  assign bus.id_instr  = rst ? 32'h0 : head_q.instr;
  assign bus.id_pc     = rst ? 32'h0 : head_q.pc;
  assign bus.id_pc4    = rst ? 32'h0 : head_q.pc4;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: cycle-level queue model plus directed scenarios.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  if_fetch_queue_if bus_a ();
  if_fetch_queue_if bus_b ();

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC_A)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a.master)
  );
  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC_B)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b.master)
  );

  // Instruction memory: word index as data one cycle after a request, noise otherwise
  always @(posedge clk) bus_a.imem_rdata <= bus_a.imem_req ? (bus_a.imem_addr >> 2) : $urandom();
  always @(posedge clk) bus_b.imem_rdata <= bus_b.imem_req ? (bus_b.imem_addr >> 2) : $urandom();

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of buffered PCs, one outstanding fetch, next fetch PC
  logic [31:0] mq[$];
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_fetch;

  // Inputs and predictions of the current cycle
  bit          c_r, c_rv, c_rdy, c_pop, c_req;
  logic [31:0] c_rpc;
  logic [31:0] e_hd;
  logic [129:0] exp_v, obs_v;

  task automatic apply(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    logic v;
    logic [31:0] hd;
    @(negedge clk);
    rst_a                = r;
    bus_a.redirect_valid = rv;
    bus_a.redirect_pc    = rpc;
    bus_a.id_ready       = rdy;
    #1;
    c_r = r; c_rv = rv; c_rpc = rpc; c_rdy = rdy;
    if (r) begin
      c_pop = 1'b0; c_req = 1'b0; e_hd = 32'h0;
      exp_v = {1'b0, RPC_A, 1'b0, 96'h0};
    end else begin
      v     = (mq.size() != 0);
      hd    = v ? mq[0] : 32'h0;
      e_hd  = hd;
      c_pop = v && rdy;
      c_req = !rv && ((int'(mq.size()) + int'(m_inf) - int'(c_pop)) < int'(DEPTH));
      exp_v = {c_req, m_fetch, v, v ? (hd >> 2) : 32'h0, hd, v ? hd + 32'd4 : 32'h0};
    end
    obs_v = {bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid,
             bus_a.id_instr, bus_a.id_pc, bus_a.id_pc4};
  endtask

  task automatic advance();
    if (c_r) begin
      mq.delete(); m_inf = 1'b0; m_fetch = RPC_A;
    end else if (c_rv) begin
      mq.delete(); m_inf = 1'b0; m_fetch = c_rpc & 32'hFFFF_FFFC;
    end else begin
      if (c_pop) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_pc);
      m_inf = c_req;
      if (c_req) begin
        m_inf_pc = m_fetch;
        m_fetch  = m_fetch + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b1);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL reset_state: got %h want %h", obs_v, exp_v);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_startup();
    int first_req = -1;
    int first_val = -1;
    logic [31:0] pops[$];
    logic [31:0] got;
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL startup_cyc%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      if (bus_a.imem_req && first_req < 0) first_req = i;
      if (bus_a.id_valid && first_val < 0) first_val = i;
      if (bus_a.id_valid && bus_a.id_ready) pops.push_back(bus_a.id_pc);
      advance();
    end
    n_chk++;
    if (first_req !== 0) $display("FAIL startup_first_req: got %0d want 0", first_req);
    else n_pass++;
    n_chk++;
    if (first_val !== 2) $display("FAIL startup_first_valid: got %0d want 2", first_val);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      got = (k < pops.size()) ? pops[k] : 32'hDEAD_BEEF;
      n_chk++;
      if (got !== 32'(4 * k)) $display("FAIL startup_pc%0d: got %h want %h", k, got, 32'(4 * k));
      else n_pass++;
    end
    n_chk++;
    if (pops.size() != 6) $display("FAIL startup_throughput: got %0d pops want 6", pops.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] head;
    logic [31:0] got;
    logic [31:0] pops[$];
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL stall_cyc%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      if (i == 5) begin
        n_chk++;
        if (bus_a.imem_req !== 1'b0 || bus_a.id_valid !== 1'b1)
          $display("FAIL stall_full: got req=%b valid=%b want req=0 valid=1",
                   bus_a.imem_req, bus_a.id_valid);
        else n_pass++;
      end
      head = e_hd;
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL release_cyc%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      if (i == 0) begin
        n_chk++;
        if (bus_a.imem_req !== 1'b1) $display("FAIL release_req: got %b want 1", bus_a.imem_req);
        else n_pass++;
      end
      if (bus_a.id_valid && bus_a.id_ready) pops.push_back(bus_a.id_pc);
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < pops.size()) ? pops[k] : 32'hDEAD_BEEF;
      n_chk++;
      if (got !== head + 32'(4 * k))
        $display("FAIL release_order%0d: got %h want %h", k, got, head + 32'(4 * k));
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    int stale = 0;
    int first_val = -1;
    logic [31:0] first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      advance();
    end
    apply(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL redir_cycle: got %h want %h", obs_v, exp_v);
    else n_pass++;
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_chk++;
    if (bus_a.id_valid !== 1'b0 || bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h0000_0100)
      $display("FAIL redir_next: got valid=%b req=%b addr=%h want 0 1 00000100",
               bus_a.id_valid, bus_a.imem_req, bus_a.imem_addr);
    else n_pass++;
    advance();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL redir_cyc%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      if (bus_a.id_valid) begin
        if (first_val < 0) begin first_val = i; first_pc = bus_a.id_pc; end
        if (bus_a.id_pc < 32'h100 || bus_a.id_pc >= 32'h140) stale++;
      end
      advance();
    end
    n_chk++;
    if (stale != 0) $display("FAIL redir_stale: got %0d stale pcs want 0", stale);
    else n_pass++;
    n_chk++;
    if (first_val != 1 || first_pc !== 32'h100)
      $display("FAIL redir_target: got idx %0d pc %h want idx 1 pc 00000100", first_val, first_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_pop();
    logic [31:0] tgt;
    logic [31:0] got;
    logic [31:0] pops[$];
    tgt = 32'h0000_2000 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      advance();
    end
    apply(1'b0, 1'b1, tgt | 32'h1, 1'b1);
    n_chk++;
    if (obs_v !== exp_v || bus_a.id_valid !== 1'b1)
      $display("FAIL redir_pop_cycle: got %h want %h", obs_v, exp_v);
    else n_pass++;
    advance();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL redir_pop_cyc%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      if (bus_a.id_valid && bus_a.id_ready) pops.push_back(bus_a.id_pc);
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      got = (k < pops.size()) ? pops[k] : 32'hDEAD_BEEF;
      n_chk++;
      if (got !== tgt + 32'(4 * k))
        $display("FAIL redir_pop_seq%0d: got %h want %h", k, got, tgt + 32'(4 * k));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit rdy, rv;
    for (int i = 0; i < 300; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      apply(1'b0, rv, $urandom(), rdy);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL random_cyc%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int first_req = -1;
    logic [31:0] req_addr = 32'hDEAD_BEEF;
    logic [31:0] first_pc = 32'hDEAD_BEEF;
    int stale = 0;
    apply(1'b0, 1'b1, 32'h0000_8000, 1'b1);
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      advance();
    end
    apply(1'b1, 1'b1, 32'h0000_4000, 1'b0);
    n_chk++;
    if (bus_a.id_valid !== 1'b0 || bus_a.imem_req !== 1'b0)
      $display("FAIL midreset_outputs: got valid=%b req=%b want 0 0", bus_a.id_valid, bus_a.imem_req);
    else n_pass++;
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL midreset_cycle: got %h want %h", obs_v, exp_v);
    else n_pass++;
    advance();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL midreset_cyc%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      if (bus_a.imem_req && first_req < 0) begin first_req = i; req_addr = bus_a.imem_addr; end
      if (bus_a.id_valid) begin
        if (first_pc === 32'hDEAD_BEEF) first_pc = bus_a.id_pc;
        if (bus_a.id_pc >= 32'h40) stale++;
      end
      advance();
    end
    n_chk++;
    if (req_addr !== RPC_A) $display("FAIL midreset_req_addr: got %h want %h", req_addr, RPC_A);
    else n_pass++;
    n_chk++;
    if (first_pc !== RPC_A || stale != 0)
      $display("FAIL midreset_no_stale: got first %h stale %0d want %h 0", first_pc, stale, RPC_A);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] pops[$];
    logic [31:0] want[4];
    logic [31:0] got;
    int bad = 0;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000; want[3] = 32'h0000_0004;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst_b          = (i == 0);
      bus_b.id_ready = 1'b1;
      #1;
      if (!rst_b && bus_b.id_valid) begin
        pops.push_back(bus_b.id_pc);
        if (bus_b.id_instr !== (bus_b.id_pc >> 2) || bus_b.id_pc4 !== bus_b.id_pc + 32'd4) bad++;
      end
      @(posedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < pops.size()) ? pops[k] : 32'hDEAD_BEEF;
      n_chk++;
      if (got !== want[k]) $display("FAIL wrap_pc%0d: got %h want %h", k, got, want[k]);
      else n_pass++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL wrap_payload: got %0d bad entries want 0", bad);
    else n_pass++;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc    = 32'h0;
    bus_a.id_ready       = 1'b1;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = 32'h0;
    bus_b.id_ready       = 1'b1;
    m_inf    = 1'b0;
    m_inf_pc = 32'h0;
    m_fetch  = RPC_A;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
